seg_display_scheduler: RTL and testbench
========================================

# seg_display_scheduler

Owns the 4-digit active-low 7-segment display and decides what it shows. It time-multiplexes the four digits with inter-digit blanking to suppress ghosting. It arbitrates between a background source (the running counter value) and a one-shot overlay message that holds the display for a fixed number of frames. All display content changes only at frame boundaries, so a frame never shows digits from two different values.

## Interface
Parameters:
- DIGIT_CYCLES, 100000, clk cycles each digit is lit (1 ms at 100 MHz); minimum 1
- BLANK_CYCLES, 1000, clk cycles all anodes are off before each digit; minimum 1
- HOLD_FRAMES, 500, full frames the overlay owns the display after a request; minimum 1

Ports:
- clk  in  1  system clock; one clock domain, all logic on posedge
- btnC  in  1  reset; synchronous, active-high
- bg_bcd  in  16  background value, 4 BCD nibbles, [15:12] = leftmost digit
- ovl_bcd  in  16  overlay value, sampled only when ovl_req=1
- ovl_req  in  1  single-cycle overlay request strobe
- lz_blank  in  1  leading-zero blanking enable, sampled at frame start
- ovl_busy  out  1  overlay pending or currently displayed
- frame_tick  out  1  one-cycle pulse at each frame boundary
- an  out  4  anodes, active-low
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low

## Operation
- Scan FSM states:
  - BLANK: an=4'b1111, seg=7'b1111111, lasts BLANK_CYCLES.
  - ON: one anode low, lasts DIGIT_CYCLES.
- Digit order is 0..3 = an 0111, 1011, 1101, 1110; the digit index wraps 3 -> 0.
- A frame is BLANK+ON for all four digits: 4*(BLANK_CYCLES+DIGIT_CYCLES) cycles.
- Frame boundary: the cycle entering BLANK for digit 0. At that cycle:
  - frame_tick=1;
  - the owner is decided;
  - a 16-bit snapshot is loaded from the owner's source (bg_bcd live, or the overlay pending register);
  - lz_blank is latched.
- Owner FSM:
  - BG: owner is the background.
  - OVL: owner is the overlay.
  - BG->OVL at a frame boundary when the pending flag is set; this clears pending and loads hold_cnt=HOLD_FRAMES.
  - In OVL, hold_cnt decrements at each frame boundary.
  - OVL->BG at the boundary where hold_cnt would reach 0, unless pending is set; if pending is set, reload and stay in OVL.
- ovl_req=1: ovl_bcd is captured into the pending register the same cycle and pending is set. A new request overwrites any earlier one, including while in OVL. A request on a frame boundary cycle is honoured at that boundary.
- ovl_busy = pending | (owner==OVL), registered.
- Decode (registered seg):
  - nibbles 0..9 use the codebase patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000;
  - nibbles 10..15 show '-' = 0111111.
- Leading-zero blanking: with lz_blank latched 1, digit k (k<3) is blanked if the snapshot nibble for it and all more-significant nibbles are 0. Blanked means the anode stays 1111 during its ON slot. Digit 3 is never blanked.
- Reset state:
  - owner BG, pending=0, hold_cnt=0, snapshot=0;
  - scan enters BLANK for digit 0 with its counter at 0;
  - an=1111, seg=1111111, ovl_busy=0, frame_tick=0.
- Reset asserted mid-operation aborts any overlay and returns the block to the reset state on the next edge.

## Timing
- an, seg, ovl_busy and frame_tick are all registered. an and seg switch together, on the same edge as the scan state change.
- First frame_tick is the first cycle after btnC deasserts; it loads a snapshot of bg_bcd. First lit digit comes BLANK_CYCLES cycles later.
- Overlay latency: a request appears at the next frame boundary, at most one frame. A request arriving k cycles before a boundary is shown from that boundary.
- Overlay display time is exactly HOLD_FRAMES frames after the last request.
- ovl_busy rises one cycle after ovl_req. It falls on the cycle after the boundary that returns the owner to BG.
- Scan counters never stall; arbitration never stretches or shortens a slot.

## Structure
- Shared package seg_pkg holds:
  - the segment pattern constants (digits 0..9, SEG_DASH, SEG_OFF);
  - AN_OFF;
  - the scan state encodings (BLANK, ON);
  - the owner state encodings (BG, OVL).
- One sub-module, seg7_decode: a combinational 4-bit nibble to 7-bit active-low pattern decoder, registered in the parent.
- Scan FSM and owner FSM live in the parent, seg_display_scheduler.

## Test plan
All scenarios use DIGIT_CYCLES=4, BLANK_CYCLES=1, HOLD_FRAMES=2, so a frame is 20 cycles.
- Reset/scan: hold btnC 3 cycles, bg_bcd=16'h1234 -> an=1111 and seg=1111111 during reset; frame_tick on the first cycle after release; then per 5-cycle slot an 0111/1011/1101/1110 with seg 1111001/0100100/0110000/0011001.
- Tear-free: change bg_bcd from 16'h1234 to 16'h5678 mid-frame -> the current frame completes as 1234; 5678 appears from the next frame_tick.
- Overlay hold: ovl_req with ovl_bcd=16'h9999 -> ovl_busy=1 next cycle; exactly 2 frames show 9999; then background returns and ovl_busy=0 the cycle after that boundary.
- Re-request: second ovl_req with 16'h0042 during the first overlay frame -> the next frame shows 0042; the hold restarts for 2 frames from there.
- Boundary collision: ovl_req with 16'h0007 on the exact frame_tick cycle where the hold expires -> the owner stays OVL and 0007 is shown at that boundary.
- Blanking/invalid: lz_blank=1, bg_bcd=16'h0050 -> digits 0 and 1 keep an=1111, digits 2 and 3 show 5 and 0. bg_bcd=16'h00A0 with lz_blank=0 -> digit 2 shows 0111111.

Source files
------------

// File: rtl/seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : seg_pkg                                                    |
// | Brief   : Shared 7-segment patterns, anode constants, FSM encodings  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package seg_pkg;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [3:0] AN_OFF   = 4'b1111;

    typedef enum logic [0:0] {
        SCAN_BLANK = 1'b0,
        SCAN_ON    = 1'b1
    } scan_state_t;

    typedef enum logic [0:0] {
        OWN_BG  = 1'b0,
        OWN_OVL = 1'b1
    } owner_state_t;

    // Digit 0 is the leftmost position, driven by an[3]
    function automatic logic [3:0] digit_anode(input logic [1:0] digit);
        return ~(4'b1000 >> digit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : seg7_decode                                                |
// | Brief   : BCD nibble to active-low 7-segment pattern, dash if > 9    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_nibble)
            4'd0: o_seg = SEG_0;
            4'd1: o_seg = SEG_1;
            4'd2: o_seg = SEG_2;
            4'd3: o_seg = SEG_3;
            4'd4: o_seg = SEG_4;
            4'd5: o_seg = SEG_5;
            4'd6: o_seg = SEG_6;
            4'd7: o_seg = SEG_7;
            4'd8: o_seg = SEG_8;
            4'd9: o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_display_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : seg_display_scheduler                                      |
// | Brief   : 4-digit scan with blanking, background/overlay arbitration |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seg_display_scheduler
    import seg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int HOLD_FRAMES  = 500
) (
    input  logic        clk,
    input  logic        btnC,
    input  logic [15:0] bg_bcd,
    input  logic [15:0] ovl_bcd,
    input  logic        ovl_req,
    input  logic        lz_blank,
    output logic        ovl_busy,
    output logic        frame_tick,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int HW      = $clog2(HOLD_FRAMES + 1);

    // Scan registers name the slot shown in the *next* cycle; outputs lag them by one edge
    scan_state_t  r_scan;
    logic [1:0]   r_digit;
    logic [CW-1:0] r_cnt;

    owner_state_t r_owner;
    logic         r_pending;
    logic [15:0]  r_ovl_val;
    logic [HW-1:0] r_hold;
    logic [15:0]  r_snap;
    logic         r_lz;
    logic         r_frame_tick;
    logic [3:0]   r_an;
    logic [6:0]   r_seg;
    logic         r_busy;

    logic         w_req_pend;
    logic [15:0]  w_ovl_val;
    owner_state_t w_owner_nxt;
    logic         w_pend_nxt;
    logic [HW-1:0] w_hold_nxt;
    logic [15:0]  w_snap_nxt;
    logic         w_lz_nxt;
    logic [3:0]   w_nibble;
    logic         w_lead_zero;
    logic         w_digit_blank;
    logic [6:0]   w_seg_dec;
    logic         w_slot_last;

    assign w_req_pend = r_pending | ovl_req;
    assign w_ovl_val  = ovl_req ? ovl_bcd : r_ovl_val;

    // Arbitration commits on the edge closing the frame_tick cycle
    always_comb begin
        w_owner_nxt = r_owner;
        w_pend_nxt  = w_req_pend;
        w_hold_nxt  = r_hold;
        w_snap_nxt  = r_snap;
        w_lz_nxt    = r_lz;
        if (r_frame_tick) begin
            w_lz_nxt = lz_blank;
            if (w_req_pend) begin
                w_owner_nxt = OWN_OVL;
                w_pend_nxt  = 1'b0;
                w_hold_nxt  = HW'(HOLD_FRAMES);
                w_snap_nxt  = w_ovl_val;
            end else if (r_owner == OWN_OVL && r_hold > HW'(1)) begin
                w_hold_nxt  = r_hold - HW'(1);
            end else begin
                w_owner_nxt = OWN_BG;
                w_hold_nxt  = '0;
                w_snap_nxt  = bg_bcd;
            end
        end
    end

    always_comb begin
        w_nibble    = w_snap_nxt[3:0];
        w_lead_zero = 1'b0;
        case (r_digit)
            2'd0: begin w_nibble = w_snap_nxt[15:12]; w_lead_zero = (w_snap_nxt[15:12] == 4'd0); end
            2'd1: begin w_nibble = w_snap_nxt[11:8];  w_lead_zero = (w_snap_nxt[15:8]  == 8'd0); end
            2'd2: begin w_nibble = w_snap_nxt[7:4];   w_lead_zero = (w_snap_nxt[15:4]  == 12'd0); end
            default: begin w_nibble = w_snap_nxt[3:0]; w_lead_zero = 1'b0; end
        endcase
    end

    assign w_digit_blank = w_lz_nxt & w_lead_zero;
    assign w_slot_last   = (r_scan == SCAN_BLANK) ? (r_cnt == CW'(BLANK_CYCLES - 1))
                                                  : (r_cnt == CW'(DIGIT_CYCLES - 1));

    seg7_decode u_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_dec)
    );

    always_ff @(posedge clk) begin
        if (btnC) begin
            r_scan       <= SCAN_BLANK;
            r_digit      <= 2'd0;
            r_cnt        <= '0;
            r_owner      <= OWN_BG;
            r_pending    <= 1'b0;
            r_ovl_val    <= '0;
            r_hold       <= '0;
            r_snap       <= '0;
            r_lz         <= 1'b0;
            r_frame_tick <= 1'b0;
            r_an         <= AN_OFF;
            r_seg        <= SEG_OFF;
            r_busy       <= 1'b0;
        end else begin
            r_owner      <= w_owner_nxt;
            r_pending    <= w_pend_nxt;
            r_ovl_val    <= w_ovl_val;
            r_hold       <= w_hold_nxt;
            r_snap       <= w_snap_nxt;
            r_lz         <= w_lz_nxt;
            r_busy       <= w_pend_nxt | (w_owner_nxt == OWN_OVL);
            r_frame_tick <= (r_scan == SCAN_BLANK) && (r_digit == 2'd0) && (r_cnt == '0);

            if (r_scan == SCAN_ON && !w_digit_blank) begin
                r_an  <= digit_anode(r_digit);
                r_seg <= w_seg_dec;
            end else begin
                r_an  <= AN_OFF;
                r_seg <= SEG_OFF;
            end

            if (!w_slot_last) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
                if (r_scan == SCAN_BLANK) begin
                    r_scan <= SCAN_ON;
                end else begin
                    r_scan  <= SCAN_BLANK;
                    r_digit <= r_digit + 2'd1;
                end
            end
        end
    end

    assign ovl_busy   = r_busy;
    assign frame_tick = r_frame_tick;
    assign an         = r_an;
    assign seg        = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_seg_display_scheduler                                   |
// | Brief   : Directed frame-by-frame checks of scan, overlay and blanking|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_seg_display_scheduler;

    logic        clk = 1'b0;
    logic        btnC;
    logic [15:0] bg_bcd;
    logic [15:0] ovl_bcd;
    logic        ovl_req;
    logic        lz_blank;
    logic        ovl_busy;
    logic        frame_tick;
    logic [3:0]  an;
    logic [6:0]  seg;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int K_NONE  = 0;
    localparam int K_BG    = 1;
    localparam int K_REQ   = 2;
    localparam int K_BG_LZ = 3;
    localparam int K_BG_NZ = 4;

    seg_display_scheduler #(
        .DIGIT_CYCLES (4),
        .BLANK_CYCLES (1),
        .HOLD_FRAMES  (2)
    ) dut (
        .clk        (clk),
        .btnC       (btnC),
        .bg_bcd     (bg_bcd),
        .ovl_bcd    (ovl_bcd),
        .ovl_req    (ovl_req),
        .lz_blank   (lz_blank),
        .ovl_busy   (ovl_busy),
        .frame_tick (frame_tick),
        .an         (an),
        .seg        (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] model_seg(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Entered at the negedge of a frame_tick cycle; leaves at the next one (20 cycles later)
    task automatic run_frame(input string tag, input logic [15:0] val, input logic lz,
                             input logic busy0, input logic busy1,
                             input int act_c, input int act_kind, input logic [15:0] act_val);
        int         k;
        logic [3:0] nib;
        logic       blank;
        logic [3:0] exp_an;
        for (int c = 0; c < 20; c++) begin
            if (c == 0) begin
                check($sformatf("%s tick", tag), {31'd0, frame_tick}, 32'd1);
                check($sformatf("%s busy@tick", tag), {31'd0, ovl_busy}, {31'd0, busy0});
            end
            if (c == 1) begin
                check($sformatf("%s tick_low", tag), {31'd0, frame_tick}, 32'd0);
                check($sformatf("%s busy@1", tag), {31'd0, ovl_busy}, {31'd0, busy1});
            end
            if (act_kind == K_REQ && c == act_c + 1)
                check($sformatf("%s busy_after_req", tag), {31'd0, ovl_busy}, 32'd1);
            if (c % 5 == 0)
                check($sformatf("%s blank_an c%0d", tag, c), {28'd0, an}, 32'hF);
            if (c % 5 == 1) begin
                k      = c / 5;
                nib    = 4'((val >> (12 - 4 * k)) & 16'hF);
                blank  = lz && (k < 3) && ((val >> (12 - 4 * k)) == 16'd0);
                exp_an = blank ? 4'b1111 : ~(4'b1000 >> k);
                check($sformatf("%s an d%0d", tag, k), {28'd0, an}, {28'd0, exp_an});
                if (!blank)
                    check($sformatf("%s seg d%0d", tag, k), {25'd0, seg}, {25'd0, model_seg(nib)});
            end
            ovl_req = 1'b0;
            if (c == act_c) begin
                case (act_kind)
                    K_BG:    bg_bcd = act_val;
                    K_REQ:   begin ovl_req = 1'b1; ovl_bcd = act_val; end
                    K_BG_LZ: begin bg_bcd = act_val; lz_blank = 1'b1; end
                    K_BG_NZ: begin bg_bcd = act_val; lz_blank = 1'b0; end
                    default: ;
                endcase
            end
            @(negedge clk);
        end
        ovl_req = 1'b0;
    endtask

    initial begin
        btnC     = 1'b1;
        bg_bcd   = 16'h1234;
        ovl_bcd  = 16'h0000;
        ovl_req  = 1'b0;
        lz_blank = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst an", {28'd0, an}, 32'hF);
        check("rst seg", {25'd0, seg}, 32'h7F);
        check("rst tick", {31'd0, frame_tick}, 32'd0);
        check("rst busy", {31'd0, ovl_busy}, 32'd0);
        btnC = 1'b0;
        @(negedge clk);

        run_frame("F1_1234",  16'h1234, 1'b0, 1'b0, 1'b0, 10, K_BG,    16'h5678);
        run_frame("F2_5678",  16'h5678, 1'b0, 1'b0, 1'b0, 7,  K_REQ,   16'h9999);
        run_frame("F3_9999",  16'h9999, 1'b0, 1'b1, 1'b1, -1, K_NONE,  16'h0000);
        run_frame("F4_9999",  16'h9999, 1'b0, 1'b1, 1'b1, -1, K_NONE,  16'h0000);
        run_frame("F5_bg",    16'h5678, 1'b0, 1'b1, 1'b0, 5,  K_REQ,   16'h9999);
        run_frame("F6_9999",  16'h9999, 1'b0, 1'b1, 1'b1, 8,  K_REQ,   16'h0042);
        run_frame("F7_0042",  16'h0042, 1'b0, 1'b1, 1'b1, -1, K_NONE,  16'h0000);
        run_frame("F8_0042",  16'h0042, 1'b0, 1'b1, 1'b1, -1, K_NONE,  16'h0000);
        run_frame("F9_0007",  16'h0007, 1'b0, 1'b1, 1'b1, 0,  K_REQ,   16'h0007);
        run_frame("F10_0007", 16'h0007, 1'b0, 1'b1, 1'b1, -1, K_NONE,  16'h0000);
        run_frame("F11_bg",   16'h5678, 1'b0, 1'b1, 1'b0, 10, K_BG_LZ, 16'h0050);
        run_frame("F12_lz",   16'h0050, 1'b1, 1'b0, 1'b0, 10, K_BG_NZ, 16'h00A0);
        run_frame("F13_dash", 16'h00A0, 1'b0, 1'b0, 1'b0, 12, K_REQ,   16'h1234);

        // Reset lands on the boundary where the pending overlay would have taken over
        btnC = 1'b1;
        @(negedge clk);
        check("midrst an", {28'd0, an}, 32'hF);
        check("midrst seg", {25'd0, seg}, 32'h7F);
        check("midrst busy", {31'd0, ovl_busy}, 32'd0);
        check("midrst tick", {31'd0, frame_tick}, 32'd0);
        btnC = 1'b0;
        @(negedge clk);
        run_frame("F14_after_rst", 16'h00A0, 1'b0, 1'b0, 1'b0, -1, K_NONE, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
